// File: rtl/alu_mul_seq_pkg.sv
// Shared constants for the shift-and-add multiply sequencer: ALU opcodes,
// FSM state encoding and a small state-decode helper.
package alu_mul_seq_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_NOP = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EVAL  = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } mul_state_t;

  function automatic logic is_busy(input mul_state_t s);
    return (s == ST_EVAL) || (s == ST_ADD) || (s == ST_SHIFT);
  endfunction

  function automatic logic uses_alu(input mul_state_t s);
    return (s == ST_ADD) || (s == ST_SHIFT);
  endfunction

endpackage

// File: rtl/alu_mul_seq_if.sv
// Pipeline-side request/result signals plus the shared-ALU port bundle.
// Optional ALU arbitration handshake is present only with MUL_ALU_SHARE_EN.
interface alu_mul_seq_if;
  import alu_mul_seq_pkg::*;

  logic              start;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] product;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
`ifdef MUL_ALU_SHARE_EN
  logic              alu_req;
  logic              alu_gnt;
`endif

`ifdef MUL_ALU_SHARE_EN
  modport master (
    output start, a, b, alu_result, alu_gnt,
    input  busy, done, product, alu_a, alu_b, alu_op, alu_req
  );
  modport slave (
    input  start, a, b, alu_result, alu_gnt,
    output busy, done, product, alu_a, alu_b, alu_op, alu_req
  );
`else
  modport master (
    output start, a, b, alu_result,
    input  busy, done, product, alu_a, alu_b, alu_op
  );
  modport slave (
    input  start, a, b, alu_result,
    output busy, done, product, alu_a, alu_b, alu_op
  );
`endif

endinterface

// File: rtl/alu_mul_seq.sv
// 16-bit (a*b) mod 2^16 multiplier that borrows the shared ALU for every add
// and shift. Define MUL_ALU_SHARE_EN to arbitrate for the ALU via alu_req/alu_gnt.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  alu_mul_seq_if.slave  bus
);

  mul_state_t        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] product_q, product_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              step_ok;

  // ADD/SHIFT may only commit once the ALU result really belongs to us.
`ifdef MUL_ALU_SHARE_EN
  assign step_ok = bus.alu_gnt;
`else
  assign step_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d    = '0;
          mcand_d  = bus.a;
          mplier_d = bus.b;
          state_d  = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (mplier_q == '0) begin
          product_d = acc_q;
          state_d   = ST_DONE;
        end else if (mplier_q[0]) begin
          state_d = ST_ADD;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_ADD: begin
        if (step_ok) begin
          acc_d   = bus.alu_result;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (step_ok) begin
          mcand_d  = bus.alu_result;
          mplier_d = mplier_q >> 1;
          state_d  = ST_EVAL;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = is_busy(state_d);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // ALU drive decodes straight from the current state.
  always_comb begin
    bus.alu_op = ALU_NOP;
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    case (state_q)
      ST_ADD: begin
        bus.alu_op = ALU_ADD;
        bus.alu_a  = acc_q;
        bus.alu_b  = mcand_q;
      end
      ST_SHIFT: begin
        bus.alu_op = ALU_SLL;
        bus.alu_a  = mcand_q;
        bus.alu_b  = 16'd1;
      end
      default: begin
        bus.alu_op = ALU_NOP;
        bus.alu_a  = '0;
        bus.alu_b  = '0;
      end
    endcase
  end

`ifdef MUL_ALU_SHARE_EN
  assign bus.alu_req = uses_alu(state_q);
`endif

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural model of the shared ALU.
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alu_mul_seq_if bus ();

  alu_mul_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Shared single-cycle ALU the sequencer drives.
  always_comb begin
    bus.alu_result = 16'h0000;
    case (bus.alu_op)
      ALU_AND: bus.alu_result = bus.alu_a & bus.alu_b;
      ALU_ADD: bus.alu_result = bus.alu_a + bus.alu_b;
      ALU_SUB: bus.alu_result = bus.alu_a - bus.alu_b;
      ALU_SLL: bus.alu_result = bus.alu_a << bus.alu_b[3:0];
      ALU_SRL: bus.alu_result = bus.alu_a >> bus.alu_b[3:0];
      default: bus.alu_result = 16'h0000;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one multiply and watch it for a bounded window.
  task automatic do_mul(input logic [15:0] av, input logic [15:0] bv, input bit restart,
                        input int stall_lo, input int stall_hi,
                        output int done_cyc, output int n_done, output int busy_n,
                        output int busy_at_done, output int saw_alu,
                        output logic [15:0] prod_at_done, output int stall_ok);
    int cyc;
    done_cyc = 0; n_done = 0; busy_n = 0; busy_at_done = 0; saw_alu = 0;
    prod_at_done = 16'h0; stall_ok = 1;
    @(negedge clk);
    bus.a = av; bus.b = bv; bus.start = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (cyc < 80) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
`ifdef MUL_ALU_SHARE_EN
      bus.alu_gnt = !(cyc >= stall_lo && cyc <= stall_hi);
      if (cyc >= stall_lo && cyc <= stall_hi + 1) begin
        if (!(bus.alu_req === 1'b1 && bus.alu_op === ALU_ADD && bus.alu_a === 16'h0))
          stall_ok = 0;
      end
`endif
      if (restart && cyc == 3) begin
        bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
      end
      if (bus.busy === 1'b1) busy_n++;
      if (bus.alu_op !== ALU_NOP) saw_alu = 1;
      if (bus.done === 1'b1) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc     = cyc;
          busy_at_done = int'(bus.busy);
          prod_at_done = bus.product;
          if (restart) bus.start = 1'b1;
        end
      end
      if (done_cyc > 0 && cyc >= done_cyc + 4) break;
    end
`ifdef MUL_ALU_SHARE_EN
    bus.alu_gnt = 1'b1;
`endif
    bus.start = 1'b0;
  endtask

  int          dc, nd, bn, bd, sa, so;
  logic [15:0] pr;

  initial begin
    checks = 0; failures = 0;
    clk = 1'b0; reset = 1'b0;
    bus.start = 1'b0; bus.a = 16'h0; bus.b = 16'h0;
`ifdef MUL_ALU_SHARE_EN
    bus.alu_gnt = 1'b1;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",    32'(bus.busy),    32'h0);
    chk("rst_done",    32'(bus.done),    32'h0);
    chk("rst_product", 32'(bus.product), 32'h0);
    chk("rst_alu_op",  32'(bus.alu_op),  32'(ALU_NOP));
    chk("rst_alu_a",   32'(bus.alu_a),   32'h0);
    chk("rst_alu_b",   32'(bus.alu_b),   32'h0);
`ifdef MUL_ALU_SHARE_EN
    chk("rst_alu_req", 32'(bus.alu_req), 32'h0);
`endif
    reset = 1'b1;
    @(negedge clk);

    // b = 0: straight to DONE, ALU never used
    do_mul(16'h0003, 16'h0000, 1'b0, 0, -1, dc, nd, bn, bd, sa, pr, so);
    chk("b0_done_cyc", 32'(dc), 32'd2);
    chk("b0_product",  32'(pr), 32'h0000);
    chk("b0_no_alu",   32'(sa), 32'd0);
    chk("b0_ndone",    32'(nd), 32'd1);

    // b = 1
    do_mul(16'h0005, 16'h0001, 1'b0, 0, -1, dc, nd, bn, bd, sa, pr, so);
    chk("b1_done_cyc", 32'(dc), 32'd5);
    chk("b1_product",  32'(pr), 32'h0005);

    // 7 * 5
    do_mul(16'h0007, 16'h0005, 1'b0, 0, -1, dc, nd, bn, bd, sa, pr, so);
    chk("m75_done_cyc",     32'(dc), 32'd10);
    chk("m75_product",      32'(pr), 32'h0023);
    chk("m75_busy_cycles",  32'(bn), 32'd9);
    chk("m75_busy_at_done", 32'(bd), 32'd0);
    chk("m75_product_hold", 32'(bus.product), 32'h0023);

    // wrap-around, worst-case latency
    do_mul(16'hFFFF, 16'hFFFF, 1'b0, 0, -1, dc, nd, bn, bd, sa, pr, so);
    chk("mff_done_cyc", 32'(dc), 32'd50);
    chk("mff_product",  32'(pr), 32'h0001);

    // start re-pulsed mid-run and in DONE must be ignored
    do_mul(16'h0012, 16'h0003, 1'b1, 0, -1, dc, nd, bn, bd, sa, pr, so);
    chk("rs_done_cyc", 32'(dc), 32'd8);
    chk("rs_product",  32'(pr), 32'h0036);
    chk("rs_ndone",    32'(nd), 32'd1);
    chk("rs_busy_cyc", 32'(bn), 32'd7);
    chk("rs_hold",     32'(bus.product), 32'h0036);

    // reset in cycle 4 of a run
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h00FF; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_busy",    32'(bus.busy),    32'h0);
    chk("mr_done",    32'(bus.done),    32'h0);
    chk("mr_product", 32'(bus.product), 32'h0);
    chk("mr_alu_op",  32'(bus.alu_op),  32'(ALU_NOP));
    chk("mr_alu_a",   32'(bus.alu_a),   32'h0);
    reset = 1'b1;
    do_mul(16'h0002, 16'h0004, 1'b0, 0, -1, dc, nd, bn, bd, sa, pr, so);
    chk("ar_done_cyc", 32'(dc), 32'd9);
    chk("ar_product",  32'(pr), 32'h0008);

`ifdef MUL_ALU_SHARE_EN
    // grant withheld for two cycles in the first ADD (cycles 2 and 3)
    do_mul(16'h0003, 16'h0003, 1'b0, 2, 3, dc, nd, bn, bd, sa, pr, so);
    chk("sh_done_cyc", 32'(dc), 32'd10);
    chk("sh_product",  32'(pr), 32'h0009);
    chk("sh_stall_ok", 32'(so), 32'd1);
    chk("sh_ndone",    32'(nd), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle 16-bit multiply sequencer that drives the shared single-cycle ALU with shift-and-add steps to produce `(a*b) mod 2^16`. It sits beside the execute stage: the pipeline hands it two operands, stalls on `busy`, and picks up `product` on `done`. The block owns no adder or shifter of its own; every arithmetic step goes through the ALU's ADD (3'b001) and SLL (3'b011) operations.

## Interface
- No parameters; data width is fixed at 16.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  request pulse; accepted only in IDLE.
- `a`  in  16  multiplicand; sampled on the accepting edge.
- `b`  in  16  multiplier; sampled on the accepting edge.
- `busy`  out  1  high in EVAL/ADD/SHIFT.
- `done`  out  1  one-cycle pulse in DONE.
- `product`  out  16  registered result; holds until the next accepted start.
- `alu_a`  out  16  ALU Rs operand.
- `alu_b`  out  16  ALU Rt operand.
- `alu_op`  out  3  ALU opcode.
- `alu_result`  in  16  ALU Rd output.
- `alu_req`  out  1  ALU request (only with `MUL_ALU_SHARE_EN`).
- `alu_gnt`  in  1  ALU grant (only with `MUL_ALU_SHARE_EN`).

## Operation
- Internal registers: `acc` (16), `mcand` (16), `mplier` (16).
- States are IDLE, EVAL, ADD, SHIFT and DONE.
- IDLE
  - On `start`: `acc<=0`, `mcand<=a`, `mplier<=b`, go to EVAL.
  - Otherwise stay in IDLE.
- EVAL
  - If `mplier==0`: go to DONE and load `product<=acc`.
  - Else if `mplier[0]`: go to ADD.
  - Else: go to SHIFT.
- ADD
  - Drive `alu_op=3'b001`, `alu_a=acc`, `alu_b=mcand`.
  - `acc<=alu_result`, then go to SHIFT.
- SHIFT
  - Drive `alu_op=3'b011`, `alu_a=mcand`, `alu_b=16'd1`.
  - `mcand<=alu_result`, `mplier<=mplier>>1` (internal shift), then go to EVAL.
- DONE: assert `done`, then go to IDLE.
- ALU outputs in IDLE/EVAL/DONE: `alu_op=3'b111` (ALU yields 0), `alu_a=alu_b=0`. These are combinational from state.
- Arithmetic is modulo 2^16, and ALU carries are discarded. Termination is guaranteed: `mplier` reaches 0 after at most 16 shifts.
- `start` is ignored in every state except IDLE, including DONE. `a`/`b` changing after acceptance has no effect.
- Reset low on any edge, including mid-operation: state becomes IDLE and `acc`, `mcand`, `mplier` and `product` all become 0. The next cycle has `busy=0`, `done=0` and the idle ALU drive.

## Timing
- Reset values: `busy=0`, `done=0`, `product=0`, `alu_op=3'b111`, `alu_a=0`, `alu_b=0`, `alu_req=0`.
- Notation: start accepted at edge 0; cycle N is the cycle after edge N-1.
- Latency to the `done` cycle = 1 + 3·(set bits of b) + 2·(clear bits of b below its MSB) + 1.
  - b=0: `done` in cycle 2.
  - b=1: `done` in cycle 5.
  - b=0xFFFF: `done` in cycle 50.
- `product` is valid from the `done` cycle onward.
- `busy` is low during the `done` cycle. The earliest next acceptance is the edge ending the first IDLE cycle after DONE.

## Configuration
- `MUL_ALU_SHARE_EN` defined:
  - `alu_req` and `alu_gnt` exist.
  - `alu_req` is high throughout ADD and SHIFT.
  - The state transition and register update happen only on an edge where `alu_gnt=1`. Otherwise the state holds with outputs stable.
  - `alu_gnt` is ignored outside ADD/SHIFT.
  - Each ungranted cycle adds one cycle of latency.
- `MUL_ALU_SHARE_EN` undefined:
  - No `alu_req`/`alu_gnt` ports.
  - The ALU is exclusively owned during `busy`, and ADD/SHIFT always advance.

## Structure
- Shared package/include holds:
  - ALU opcode constants `ALU_AND=3'b000`, `ALU_ADD=3'b001`, `ALU_SUB=3'b010`, `ALU_SLL=3'b011`, `ALU_SRL=3'b100`, `ALU_NOP=3'b111`.
  - The 3-bit state encoding for IDLE/EVAL/ADD/SHIFT/DONE.
- Single module, no sub-module: FSM and the three datapath registers are tightly coupled.
- The bench instantiates the existing ALU and connects it to the `alu_*` ports.

## Test plan
- a=0x0003, b=0x0000 -> `done` in cycle 2, `product=0x0000`, no ADD/SHIFT states visited.
- a=0x0007, b=0x0005 -> `done` in cycle 1+3+2+3+1=10, `product=0x0023`, `busy` high cycles 1–9.
- a=0xFFFF, b=0xFFFF -> `done` in cycle 50, `product=0x0001` (wrap-around).
- `start` pulsed again in cycles 3 and in the DONE cycle of a=0x0012,b=0x0003 run -> ignored, `product=0x0036`, single `done` pulse.
- reset low in cycle 4 of a=0x1234,b=0x00FF -> next cycle IDLE, `busy=0`, `product=0`. Subsequent start a=0x0002,b=0x0004 gives `product=0x0008`.
- (`MUL_ALU_SHARE_EN`) a=3, b=3, `alu_gnt` low for 2 cycles in the first ADD -> `alu_req` held high, `acc` unchanged while stalled, `done` 2 cycles late (cycle 10), `product=0x0009`.
